avanco_ctrl: RTL and testbench
==============================

# avanco_ctrl

Parametrised motion/cleaning action sequencer for the pipe-cleaner robot. It samples the advance/remove commands and the current orientation on every `clockc3` edge and issues a registered 3-bit action code to the drive stage. Beyond plain direction selection, it adds:
- a configurable remove-request threshold;
- a multi-cycle, non-interruptible cleaning burst with a busy flag;
- saturating step and cleaning counters;
- an invalid-orientation error pulse.

## Interface
Parameters:
- `REMOVE_THRESH`, default 3: number of consecutive remove cycles that triggers cleaning; legal range 1..15.
- `CLEAN_CYCLES`, default 4: number of cycles `acao` holds LIMPAR per burst; legal range 1..255.
- `STEP_W`, default 8: width of the `passos` step counter.
- `CNT_W`, default 4: width of the `limpezas` cleaning counter.

Ports:
- `clockc3`, input, 1: system clock; all logic samples on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset; asserting it clears all state immediately.
- `avancar`, input, 1: advance request.
- `remover`, input, 1: remove/clean request.
- `orientacao`, input, 3: heading code. 001=N, 010=O, 011=L, 100=S; all other codes are invalid.
- `acao`, output, 3: action code. 000=parado, 001..100 = move in the matching heading, 101=limpar.
- `ocupado`, output, 1: high while a cleaning burst is in progress.
- `passos`, output, `STEP_W`: count of issued moves; saturates at all-ones.
- `limpezas`, output, `CNT_W`: count of started cleaning bursts; saturates at all-ones.
- `erro`, output, 1: one-cycle pulse on an advance request with an invalid heading.

## Operation
- States are PARADO, MOVER and LIMPAR. `acao` is 000 in PARADO, the heading code in MOVER, and 101 in LIMPAR.
- Decision rules apply whenever the block is not in LIMPAR, or on the final LIMPAR cycle. Priority is `avancar` > `remover` > idle.
  - `avancar`=1 with a valid heading: go to MOVER, `acao`=`orientacao`, `passos`+1, clear the remove counter.
  - `avancar`=1 with an invalid heading: go to PARADO, `erro`=1 for that cycle, clear the remove counter.
  - `avancar`=0, `remover`=1, remove counter < `REMOVE_THRESH`-1: increment the counter and go to PARADO.
  - `avancar`=0, `remover`=1, remove counter = `REMOVE_THRESH`-1: go to LIMPAR, clear the counter, load the burst counter with `CLEAN_CYCLES`-1, `limpezas`+1.
  - Both inputs 0: go to PARADO and clear the remove counter. The count requires consecutive remove cycles.
- LIMPAR behaviour:
  - Both inputs are ignored and the remove counter holds 0.
  - The burst counter decrements each edge.
  - On the edge where the burst counter is 0, the decision rules above determine the next state, so back-to-back bursts and move-after-clean incur no idle gap.
- With `REMOVE_THRESH`=1, a single remove cycle starts a burst.
- Counters saturate: once at all-ones, further increments leave the value unchanged.

## Timing
- Every output is registered. `acao`, `ocupado` and `erro` reflect the inputs sampled at the preceding rising edge, so latency is one edge.
- A burst makes `acao`=101 and `ocupado`=1 for exactly `CLEAN_CYCLES` consecutive cycles.
- Reset values: `acao`=000, `ocupado`=0, `erro`=0, `passos`=0, `limpezas`=0. The state returns to PARADO and the remove and burst counters clear to 0.
- Reset asserted mid-burst aborts the burst immediately, with outputs at their reset values. After reset is released, the first edge applies the decision rules.
- `erro` is never high for two consecutive cycles unless the invalid advance request persists.

## Structure
- Shared package `avanco_pkg` holds:
  - the 3-bit action/heading localparams (PARADO=000, N=001, O=010, L=011, S=100, LIMPAR=101);
  - the state enum typedef {PARADO, MOVER, LIMPAR};
  - the function `orient_valida(code)`.
- Sub-module `sat_counter` (parameter W; inputs `inc` and `clear`; output `q`), instantiated twice, for `passos` and `limpezas`.
- The FSM, remove counter and burst counter stay in the top module.

## Test plan
- Reset release, then `avancar`=1 with `orientacao`=011 for 3 cycles: `acao`=011 after the first edge, `passos`=3, `erro`=0.
- `remover`=1 for 3 consecutive cycles (defaults): `acao`=000, 000, then 101 for 4 cycles with `ocupado`=1; `limpezas`=1; then `acao`=000.
- `remover` pattern 1,1,0,1,1: no burst, because the counter clears on the 0 cycle; `acao` stays 000.
- During a burst, apply `avancar`=1 with `orientacao`=001: request ignored while `ocupado`=1. If the request is still present on the final burst edge, `acao`=001 on the very next cycle.
- `avancar`=1 with `orientacao`=111: `acao`=000, `erro` pulses 1, `passos` unchanged.
- Reset asserted in burst cycle 2: all outputs go to zero at once. Separately, with `STEP_W`=2, 5 valid moves: `passos` saturates at 3.

Source files
------------

// File: rtl/avanco_pkg.sv
// avanco_pkg: shared definitions for the pipe-cleaner action sequencer.
//   - 3-bit action/heading codes driven on acao
//   - FSM state type
//   - orient_valida(): heading code validity check
package avanco_pkg;

    localparam logic [2:0] ACAO_PARADO = 3'b000;
    localparam logic [2:0] ACAO_N      = 3'b001;
    localparam logic [2:0] ACAO_O      = 3'b010;
    localparam logic [2:0] ACAO_L      = 3'b011;
    localparam logic [2:0] ACAO_S      = 3'b100;
    localparam logic [2:0] ACAO_LIMPAR = 3'b101;

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        MOVER  = 2'd1,
        LIMPAR = 2'd2
    } state_t;

    // Only N, O, L, S are real headings; 000 and 101..111 are rejected.
    function automatic logic orient_valida(input logic [2:0] code);
        return (code >= ACAO_N) && (code <= ACAO_S);
    endfunction

endpackage

// File: rtl/avanco_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   rst_n : async active-low reset, clears q
//   inc   : increment request (ignored once q is all-ones)
//   clear : synchronous clear, wins over inc
//   q     : count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/avanco_ctrl.sv
// avanco_ctrl: motion/cleaning action sequencer for the pipe-cleaner robot.
//   clockc3    : rising-edge clock
//   reset      : async active-low reset
//   avancar    : advance request (highest priority)
//   remover    : remove/clean request; REMOVE_THRESH consecutive cycles start a burst
//   orientacao : heading code 001=N 010=O 011=L 100=S, others invalid
//   acao       : registered action (000 idle, heading code when moving, 101 cleaning)
//   ocupado    : high for the CLEAN_CYCLES cycles of a cleaning burst
//   passos     : saturating count of issued moves
//   limpezas   : saturating count of started bursts
//   erro       : one-cycle pulse for an advance request with an invalid heading
module avanco_ctrl
    import avanco_pkg::*;
#(
    parameter int REMOVE_THRESH = 3,
    parameter int CLEAN_CYCLES  = 4,
    parameter int STEP_W        = 8,
    parameter int CNT_W         = 4
) (
    input  logic              clockc3,
    input  logic              reset,
    input  logic              avancar,
    input  logic              remover,
    input  logic [2:0]        orientacao,
    output logic [2:0]        acao,
    output logic              ocupado,
    output logic [STEP_W-1:0] passos,
    output logic [CNT_W-1:0]  limpezas,
    output logic              erro
);

    localparam logic [3:0] REM_LAST   = 4'(REMOVE_THRESH - 1);
    localparam logic [7:0] BURST_LOAD = 8'(CLEAN_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] rem_cnt, rem_nx;
    logic [7:0] burst_cnt, burst_nx;
    logic [2:0] acao_nx;
    logic       erro_nx;
    logic       step_inc;
    logic       clean_inc;
    logic       decide;

    // The burst counter holds the number of LIMPAR cycles still to come after
    // the current one, so a value of 0 marks the last burst cycle; that edge
    // takes a fresh decision and avoids an idle gap after the burst.
    assign decide = (state != LIMPAR) || (burst_cnt == 8'd0);

    always_comb begin
        state_nx  = state;
        rem_nx    = 4'd0;
        burst_nx  = 8'd0;
        acao_nx   = acao;
        erro_nx   = 1'b0;
        step_inc  = 1'b0;
        clean_inc = 1'b0;
        if (!decide) begin
            burst_nx = burst_cnt - 8'd1;
        end else if (avancar) begin
            if (orient_valida(orientacao)) begin
                state_nx = MOVER;
                acao_nx  = orientacao;
                step_inc = 1'b1;
            end else begin
                state_nx = PARADO;
                acao_nx  = ACAO_PARADO;
                erro_nx  = 1'b1;
            end
        end else if (remover) begin
            if (rem_cnt >= REM_LAST) begin
                state_nx  = LIMPAR;
                acao_nx   = ACAO_LIMPAR;
                burst_nx  = BURST_LOAD;
                clean_inc = 1'b1;
            end else begin
                state_nx = PARADO;
                acao_nx  = ACAO_PARADO;
                rem_nx   = rem_cnt + 4'd1;
            end
        end else begin
            state_nx = PARADO;
            acao_nx  = ACAO_PARADO;
        end
    end

    always_ff @(posedge clockc3 or negedge reset) begin
        if (!reset) begin
            state     <= PARADO;
            rem_cnt   <= 4'd0;
            burst_cnt <= 8'd0;
            acao      <= ACAO_PARADO;
            erro      <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            state     <= state_nx;
            rem_cnt   <= rem_nx;
            burst_cnt <= burst_nx;
            acao      <= acao_nx;
            erro      <= erro_nx;
            ocupado   <= (state_nx == LIMPAR);
        end
    end

    sat_counter #(.W(STEP_W)) u_passos (
        .clk   (clockc3),
        .rst_n (reset),
        .inc   (step_inc),
        .clear (1'b0),
        .q     (passos)
    );

    sat_counter #(.W(CNT_W)) u_limpezas (
        .clk   (clockc3),
        .rst_n (reset),
        .inc   (clean_inc),
        .clear (1'b0),
        .q     (limpezas)
    );

endmodule

// File: tb/tb_avanco_ctrl.sv
// tb_avanco_ctrl: two sequencer instances on shared stimulus.
//   d0: defaults (threshold 3, 4-cycle bursts, 8/4-bit counters)
//   d1: threshold 1, 1-cycle bursts, 2-bit counters (saturation corners)
// A per-cycle model tracks remaining burst cycles and the remove streak.
module tb_avanco_ctrl;

    logic       clockc3 = 1'b0;
    logic       reset;
    logic       avancar, remover;
    logic [2:0] orientacao;

    logic [2:0] acao0, acao1;
    logic       ocupado0, ocupado1, erro0, erro1;
    logic [7:0] passos0;
    logic [3:0] limpezas0;
    logic [1:0] passos1, limpezas1;

    int tests = 0;
    int fails = 0;

    always #5 clockc3 = ~clockc3;

    avanco_ctrl d0 (
        .clockc3(clockc3), .reset(reset), .avancar(avancar), .remover(remover),
        .orientacao(orientacao), .acao(acao0), .ocupado(ocupado0),
        .passos(passos0), .limpezas(limpezas0), .erro(erro0)
    );

    avanco_ctrl #(.REMOVE_THRESH(1), .CLEAN_CYCLES(1), .STEP_W(2), .CNT_W(2)) d1 (
        .clockc3(clockc3), .reset(reset), .avancar(avancar), .remover(remover),
        .orientacao(orientacao), .acao(acao1), .ocupado(ocupado1),
        .passos(passos1), .limpezas(limpezas1), .erro(erro1)
    );

    typedef struct {
        int acao;
        int left;    // burst cycles still showing LIMPAR, including current
        int streak;  // consecutive remove cycles seen
        int steps;
        int cleans;
        int erro;
    } m_t;

    m_t m0 = '{default: 0};
    m_t m1 = '{default: 0};

    function automatic m_t mstep(m_t s, bit a, bit r, int o,
                                 int thr, int cyc, int smax, int cmax);
        m_t n = s;
        n.erro   = 0;
        n.streak = 0;
        if (s.left > 1) begin
            n.left = s.left - 1;
            return n;
        end
        n.left = 0;
        if (a) begin
            if (o >= 1 && o <= 4) begin
                n.acao  = o;
                n.steps = (s.steps < smax) ? s.steps + 1 : s.steps;
            end else begin
                n.acao = 0;
                n.erro = 1;
            end
        end else if (r) begin
            if (s.streak + 1 >= thr) begin
                n.acao   = 5;
                n.left   = cyc;
                n.cleans = (s.cleans < cmax) ? s.cleans + 1 : s.cleans;
            end else begin
                n.acao   = 0;
                n.streak = s.streak + 1;
            end
        end else begin
            n.acao = 0;
        end
        return n;
    endfunction

    always @(posedge clockc3 or negedge reset) begin
        if (!reset) begin
            m0 <= '{default: 0};
            m1 <= '{default: 0};
        end else begin
            m0 <= mstep(m0, avancar, remover, int'(orientacao), 3, 4, 255, 15);
            m1 <= mstep(m1, avancar, remover, int'(orientacao), 1, 1, 3, 3);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clockc3) begin
        chk("d0 acao",     int'(acao0),     m0.acao);
        chk("d0 ocupado",  int'(ocupado0),  (m0.left > 0) ? 1 : 0);
        chk("d0 erro",     int'(erro0),     m0.erro);
        chk("d0 passos",   int'(passos0),   m0.steps);
        chk("d0 limpezas", int'(limpezas0), m0.cleans);
        chk("d1 acao",     int'(acao1),     m1.acao);
        chk("d1 ocupado",  int'(ocupado1),  (m1.left > 0) ? 1 : 0);
        chk("d1 erro",     int'(erro1),     m1.erro);
        chk("d1 passos",   int'(passos1),   m1.steps);
        chk("d1 limpezas", int'(limpezas1), m1.cleans);
    end

    // Drive inputs just after a falling edge; return at the next falling edge,
    // by which time the outputs reflect these inputs.
    task automatic step(input bit a, input bit r, input logic [2:0] o);
        avancar    = a;
        remover    = r;
        orientacao = o;
        @(negedge clockc3);
    endtask

    initial begin
        reset = 1'b1;
        avancar = 1'b0;
        remover = 1'b0;
        orientacao = 3'b000;
        #1 reset = 1'b0;
        @(negedge clockc3);
        chk("lit reset acao", int'(acao0), 0);
        chk("lit reset passos", int'(passos0), 0);
        @(negedge clockc3);
        reset = 1'b1;

        // three moves east
        step(1, 0, 3'b011);
        chk("lit move acao first", int'(acao0), 3);
        step(1, 0, 3'b011);
        step(1, 0, 3'b011);
        chk("lit move passos", int'(passos0), 3);
        chk("lit move erro", int'(erro0), 0);
        chk("lit d1 passos sat", int'(passos1), 3);
        step(0, 0, 3'b000);

        // three removes start a 4-cycle burst
        step(0, 1, 3'b000);
        chk("lit rem1 acao", int'(acao0), 0);
        step(0, 1, 3'b000);
        chk("lit rem2 acao", int'(acao0), 0);
        step(0, 1, 3'b000);
        chk("lit burst acao", int'(acao0), 5);
        chk("lit burst ocupado", int'(ocupado0), 1);
        chk("lit burst limpezas", int'(limpezas0), 1);
        step(0, 0, 3'b000);
        step(0, 0, 3'b000);
        step(0, 0, 3'b000);
        chk("lit burst last acao", int'(acao0), 5);
        step(0, 0, 3'b000);
        chk("lit post burst acao", int'(acao0), 0);
        chk("lit post burst ocupado", int'(ocupado0), 0);

        // broken streak 1,1,0,1,1
        step(0, 1, 3'b000);
        step(0, 1, 3'b000);
        step(0, 0, 3'b000);
        step(0, 1, 3'b000);
        step(0, 1, 3'b000);
        chk("lit streak acao", int'(acao0), 0);
        chk("lit streak limpezas", int'(limpezas0), 1);
        step(0, 0, 3'b000);

        // advance held through a burst takes effect right after it
        step(0, 1, 3'b000);
        step(0, 1, 3'b000);
        step(0, 1, 3'b000);
        step(1, 0, 3'b001);
        step(1, 0, 3'b001);
        step(1, 0, 3'b001);
        chk("lit held adv acao", int'(acao0), 5);
        chk("lit held adv passos", int'(passos0), 3);
        step(1, 0, 3'b001);
        chk("lit adv after burst", int'(acao0), 1);
        chk("lit adv after passos", int'(passos0), 4);

        // invalid heading
        step(1, 0, 3'b111);
        chk("lit bad acao", int'(acao0), 0);
        chk("lit bad erro", int'(erro0), 1);
        chk("lit bad passos", int'(passos0), 4);
        step(0, 0, 3'b000);
        chk("lit erro drops", int'(erro0), 0);

        // reset in burst cycle 2
        step(0, 1, 3'b000);
        step(0, 1, 3'b000);
        step(0, 1, 3'b000);
        step(0, 0, 3'b000);
        #1 reset = 1'b0;
        #1;
        chk("lit rst acao", int'(acao0), 0);
        chk("lit rst ocupado", int'(ocupado0), 0);
        chk("lit rst limpezas", int'(limpezas0), 0);
        chk("lit rst passos", int'(passos0), 0);
        @(negedge clockc3);
        reset = 1'b1;

        // five moves south: d1 saturates at 3
        for (int i = 0; i < 5; i++) step(1, 0, 3'b100);
        chk("lit south acao", int'(acao0), 4);
        chk("lit south passos", int'(passos0), 5);
        chk("lit d1 passos sat 5", int'(passos1), 3);

        // mixed traffic, checked by the model only
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)));
        end
        step(0, 0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
